// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: datapath enables/selects and alu_op for alu_decoder.
// Optional illegal-opcode trap state and illegal_instr port: define FSM_ILLEGAL_TRAP_EN.
module multicycle_main_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       mem_timeout
`ifdef FSM_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4 written when memory is ready
  // DECODE   | compute branch/jump target into ALUOut, dispatch on opcode
  // MEMADR   | rs1 + imm for lw/sw
  // MEMREAD  | data memory read, waits on mem_ready
  // MEMWB    | load data written back to rd
  // MEMWRITE | data memory write, held until mem_ready
  // EXECR    | rs1 op rs2
  // EXECI    | rs1 op imm
  // ALUWB    | ALUOut written back to rd
  // JAL      | PC <- target, oldPC+4 into ALUOut
  // BEQ      | rs1 - rs2, PC <- target when zero
  // TRAP     | illegal opcode, held until reset (trap build only)

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           state_q, state_d;
  logic             pc_update, branch;
  logic             ir_load, mem_wr_req, rf_wr;
  logic [CNT_W-1:0] wait_left;
  logic             timeout_q;
  logic             mem_state, waiting;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef FSM_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
`ifdef FSM_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_load    = 1'b0;
    mem_wr_req = 1'b0;
    rf_wr      = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_load    = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        rf_wr      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_wr_req = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    rf_wr = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by rst_n so an in-flight write never completes under reset.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_load;
  assign mem_write = rst_n & mem_wr_req;
  assign reg_write = rst_n & rf_wr;

  // Down-counter of remaining tolerated not-ready cycles; terminal count sets the sticky flag.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign waiting   = mem_state && !mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_left <= LIMIT;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q)
        wait_left <= LIMIT;
      else if (waiting && (wait_left != '0))
        wait_left <= wait_left - CNT_W'(1);
      if ((WAIT_LIMIT != 0) && waiting && (wait_left == CNT_W'(1)))
        timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef FSM_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: per-instruction cycle scripts vs the DUT outputs.
// Honours FSM_ILLEGAL_TRAP_EN when defined for the build.
module tb_multicycle_main_fsm;
  localparam int LIM = 15;

  typedef enum int {C_LW, C_SW, C_R, C_I, C_JAL, C_BEQ, C_NOP} cls_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [6:0] op;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, mem_timeout;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
`ifdef FSM_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif
  logic [13:0] act;

  int   errors = 0;
  int   checks = 0;
  logic to_exp = 1'b0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.WAIT_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .alu_op(alu_op), .mem_timeout(mem_timeout)
`ifdef FSM_ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  assign act = {pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, reg_write, alu_op};

  function automatic logic [13:0] vec(input bit pcw, input bit adr, input bit mw, input bit irw,
                                      input bit [1:0] rs, input bit [1:0] a, input bit [1:0] b,
                                      input bit rw, input bit [1:0] aop);
    return {pcw, adr, mw, irw, rs, a, b, rw, aop};
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, leave just after the next rise.
  task automatic step(input logic [13:0] exp, input logic rdy, input logic z, input string nm);
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs=%b expected=%b", nm, act, exp);
    end
    checks++;
    if (mem_timeout !== to_exp) begin
      errors++;
      $display("FAIL %s_timeout: mem_timeout=%b expected=%b", nm, mem_timeout, to_exp);
    end
`ifdef FSM_ILLEGAL_TRAP_EN
    checks++;
    if (illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL %s_illegal: illegal_instr=%b expected=0", nm, illegal_instr);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({pc_write, mem_write, ir_write, reg_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_enables: pc/mem/ir/reg write=%b expected=0000",
               {pc_write, mem_write, ir_write, reg_write});
    end
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout: mem_timeout=%b expected=0", mem_timeout);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    to_exp = 1'b0;
  endtask

  // Starts in FETCH, runs one whole instruction, ends with the DUT back in FETCH.
  task automatic exec_instr(input cls_t c, input int fw, input int mw, input logic z);
    logic [6:0] o;
    case (c)
      C_LW:    o = 7'b0000011;
      C_SW:    o = 7'b0100011;
      C_R:     o = 7'b0110011;
      C_I:     o = 7'b0010011;
      C_JAL:   o = 7'b1101111;
      C_BEQ:   o = 7'b1100011;
      default: begin
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
      end
    endcase
    op = o;
    for (int k = 0; k < fw; k++)
      step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, rbit(), "fetch_wait");
    step(vec(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00), 1'b1, rbit(), "fetch");
    step(vec(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00), rbit(), rbit(), "decode");
    case (c)
      C_LW: begin
        step(vec(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00), rbit(), rbit(), "lw_memadr");
        for (int k = 0; k < mw; k++)
          step(vec(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00), 1'b0, rbit(), "memread_wait");
        step(vec(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00), 1'b1, rbit(), "memread");
        step(vec(0,0,0,0,2'b01,2'b00,2'b00,1,2'b00), rbit(), rbit(), "memwb");
      end
      C_SW: begin
        step(vec(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00), rbit(), rbit(), "sw_memadr");
        for (int k = 0; k < mw; k++)
          step(vec(0,1,1,0,2'b00,2'b00,2'b00,0,2'b00), 1'b0, rbit(), "memwrite_wait");
        step(vec(0,1,1,0,2'b00,2'b00,2'b00,0,2'b00), 1'b1, rbit(), "memwrite");
      end
      C_R: begin
        step(vec(0,0,0,0,2'b00,2'b10,2'b00,0,2'b10), rbit(), rbit(), "execr");
        step(vec(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00), rbit(), rbit(), "aluwb_r");
      end
      C_I: begin
        step(vec(0,0,0,0,2'b00,2'b10,2'b01,0,2'b10), rbit(), rbit(), "execi");
        step(vec(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00), rbit(), rbit(), "aluwb_i");
      end
      C_JAL: begin
        step(vec(1,0,0,0,2'b00,2'b01,2'b10,0,2'b00), rbit(), rbit(), "jal");
        step(vec(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00), rbit(), rbit(), "aluwb_jal");
      end
      C_BEQ:
        step(vec(z,0,0,0,2'b00,2'b10,2'b00,0,2'b01), rbit(), z, "beq");
      default: ;
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    op = 7'b0110011;
    step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, 1'b0, "reset_fetch");
    exec_instr(C_R, 0, 0, 1'b0);
  endtask

  task automatic test_lw();
    exec_instr(C_LW, 0, 0, 1'b0);
  endtask

  task automatic test_sw_wait();
    exec_instr(C_SW, 0, 3, 1'b0);
  endtask

  task automatic test_alu();
    exec_instr(C_R, 0, 0, 1'b1);
    exec_instr(C_I, 1, 0, 1'b0);
    exec_instr(C_JAL, 0, 0, 1'b0);
  endtask

  task automatic test_beq();
    exec_instr(C_BEQ, 0, 0, 1'b1);
    exec_instr(C_BEQ, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    op = 7'b0110011;
    for (int k = 1; k <= LIM + 1; k++) begin
      if (k == LIM + 1) to_exp = 1'b1;
      step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, rbit(), "timeout_fetch_wait");
    end
    step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, rbit(), "timeout_sticky_wait");
    exec_instr(C_R, 0, 0, 1'b0);
    exec_instr(C_SW, 0, 1, 1'b0);
    do_reset();
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    step(vec(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00), 1'b1, 1'b0, "illegal_fetch");
    step(vec(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00), 1'b1, 1'b0, "illegal_decode");
`ifdef FSM_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      zero      = 1'b1;
      @(negedge clk);
      checks++;
      if (act !== 14'd0) begin
        errors++;
        $display("FAIL trap_outputs: outputs=%b expected=0", act);
      end
      checks++;
      if (illegal_instr !== 1'b1) begin
        errors++;
        $display("FAIL trap_flag: illegal_instr=%b expected=1", illegal_instr);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
`else
    step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, 1'b0, "illegal_nop_fetch");
`endif
  endtask

  task automatic test_reset_mid_write();
    op = 7'b0100011;
    step(vec(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00), 1'b1, 1'b0, "rmw_fetch");
    step(vec(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00), 1'b0, 1'b0, "rmw_decode");
    step(vec(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00), 1'b0, 1'b0, "rmw_memadr");
    step(vec(0,1,1,0,2'b00,2'b00,2'b00,0,2'b00), 1'b0, 1'b0, "rmw_memwrite");
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc_write, mem_write, ir_write, reg_write} !== 4'b0000) begin
      errors++;
      $display("FAIL rmw_enables: pc/mem/ir/reg write=%b expected=0000",
               {pc_write, mem_write, ir_write, reg_write});
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    to_exp = 1'b0;
    step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, 1'b0, "rmw_back_to_fetch");
  endtask

  task automatic test_random();
    cls_t c;
    for (int n = 0; n < 40; n++) begin
`ifdef FSM_ILLEGAL_TRAP_EN
      c = cls_t'($urandom_range(0, 5));
`else
      c = cls_t'($urandom_range(0, 6));
`endif
      exec_instr(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit());
    end
    step(vec(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00), 1'b0, 1'b0, "random_end_fetch");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    op        = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu();
    test_beq();
    test_timeout();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
